// File: rtl/iter_calc_if.sv
// Control/strobe bundle between iter_calc_ctrl (master) and its datapath or bench (slave).
// ABORT_EN adds the abort request and the aborted pulse.
interface iter_calc_if #(
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] n_iter;
`ifdef ABORT_EN
  logic             abort;
  logic             aborted;
`endif
  logic             busy;
  logic             done;
  logic             ld_in;
  logic             ld_acc;
  logic             ld_term;
  logic             clr_term;
  logic             ld_res;
  logic             clr_all;
  logic [1:0]       sel;
  logic [CNT_W-1:0] iter;

`ifdef ABORT_EN
  modport master (
    input  start, n_iter, abort,
    output busy, done, aborted, ld_in, ld_acc, ld_term, clr_term, ld_res, clr_all, sel, iter
  );
  modport slave (
    output start, n_iter, abort,
    input  busy, done, aborted, ld_in, ld_acc, ld_term, clr_term, ld_res, clr_all, sel, iter
  );
`else
  modport master (
    input  start, n_iter,
    output busy, done, ld_in, ld_acc, ld_term, clr_term, ld_res, clr_all, sel, iter
  );
  modport slave (
    output start, n_iter,
    input  busy, done, ld_in, ld_acc, ld_term, clr_term, ld_res, clr_all, sel, iter
  );
`endif
endinterface

// File: rtl/iter_calc_ctrl.sv
// Iterative-calculation controller: start press/release, then load/term/accumulate loop with
// optional multiplier wait states, then result load. ABORT_EN enables run cancellation.
module iter_calc_ctrl #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned MUL_LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  iter_calc_if.master bus
);

  typedef enum logic [2:0] {
    StIdle, StArm, StInit, StCalc1, StWait, StCalc2, StFin
  } state_e;

  localparam logic [3:0] WaitInit = (MUL_LAT > 0) ? 4'(MUL_LAT - 1) : 4'd0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic             done_q, done_d;
  logic             busy_s, ld_in_s, ld_acc_s, ld_term_s, clr_term_s, ld_res_s;
  logic [1:0]       sel_s;
`ifdef ABORT_EN
  logic             aborted_q, aborted_d;
`endif

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    limit_d    = limit_q;
    wcnt_d     = wcnt_q;
    done_d     = done_q;
    busy_s     = 1'b0;
    ld_in_s    = 1'b0;
    ld_acc_s   = 1'b0;
    ld_term_s  = 1'b0;
    clr_term_s = 1'b0;
    ld_res_s   = 1'b0;
    sel_s      = 2'b00;
    case (state_q)
      StIdle: if (bus.start) state_d = StArm;
      StArm:  if (!bus.start) state_d = StInit;
      StInit: begin
        busy_s     = 1'b1;
        ld_in_s    = 1'b1;
        ld_acc_s   = 1'b1;
        clr_term_s = 1'b1;
        limit_d    = bus.n_iter;
        iter_d     = '0;
        done_d     = 1'b0;
        state_d    = StCalc1;
      end
      StCalc1: begin
        busy_s = 1'b1;
        if (iter_q == limit_q) begin
          state_d = StFin;
        end else begin
          ld_term_s = 1'b1;
          sel_s     = 2'b01;
          if (MUL_LAT > 0) begin
            wcnt_d  = WaitInit;
            state_d = StWait;
          end else begin
            state_d = StCalc2;
          end
        end
      end
      StWait: begin
        busy_s = 1'b1;
        sel_s  = 2'b01;
        if (wcnt_q == 4'd0) state_d = StCalc2;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      StCalc2: begin
        busy_s   = 1'b1;
        ld_acc_s = 1'b1;
        sel_s    = 2'b10;
        iter_d   = iter_q + 1'b1;
        state_d  = StCalc1;
      end
      StFin: begin
        busy_s   = 1'b1;
        ld_res_s = 1'b1;
        sel_s    = 2'b11;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef ABORT_EN
    // Abort freezes every register except state, so a cancelled run leaves no result or done.
    aborted_d = bus.abort && busy_s;
    if (aborted_d) begin
      state_d  = StIdle;
      iter_d   = iter_q;
      limit_d  = limit_q;
      wcnt_d   = wcnt_q;
      done_d   = done_q;
      ld_res_s = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      iter_q    <= '0;
      limit_q   <= '0;
      wcnt_q    <= 4'd0;
      done_q    <= 1'b0;
`ifdef ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      limit_q   <= limit_d;
      wcnt_q    <= wcnt_d;
      done_q    <= done_d;
`ifdef ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign bus.busy     = busy_s;
  assign bus.sel      = sel_s;
  assign bus.iter     = iter_q;
  assign bus.done     = done_q;
  assign bus.ld_in    = ld_in_s    & ~reset;
  assign bus.ld_acc   = ld_acc_s   & ~reset;
  assign bus.ld_term  = ld_term_s  & ~reset;
  assign bus.clr_term = clr_term_s & ~reset;
  assign bus.ld_res   = ld_res_s   & ~reset;
  assign bus.clr_all  = reset;
`ifdef ABORT_EN
  assign bus.aborted  = aborted_q;
`endif

endmodule

// File: tb/tb_iter_calc_ctrl.sv
// Bench for iter_calc_ctrl: two DUTs (MUL_LAT 0 and 2) in lockstep against a cycle-offset model,
// plus literal checks on strobe counts and latencies. Define ABORT_EN to cover abort.
module tb_iter_calc_ctrl;
  localparam int unsigned CW = 4;
`ifdef ABORT_EN
  localparam bit AbortEn = 1'b1;
`else
  localparam bit AbortEn = 1'b0;
`endif
  localparam int MIdle = 0, MArm = 1, MRun = 2;
  localparam int PIdle = 0, PInit = 1, PTerm = 2, PFinal = 3, PWait = 4, PCalc2 = 5, PFin = 6;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [CW-1:0] n_iter;
  always #5 clk = ~clk;

  iter_calc_if #(.CNT_W(CW)) bus0 ();
  iter_calc_if #(.CNT_W(CW)) bus2 ();
  assign bus0.start = start;
  assign bus2.start = start;
  assign bus0.n_iter = n_iter;
  assign bus2.n_iter = n_iter;
`ifdef ABORT_EN
  assign bus0.abort = abort;
  assign bus2.abort = abort;
`endif

  iter_calc_ctrl #(.CNT_W(CW), .MUL_LAT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  iter_calc_ctrl #(.CNT_W(CW), .MUL_LAT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic [1:0]    busy_w, done_w, ld_in_w, ld_acc_w, ld_term_w, clr_term_w, ld_res_w, clr_all_w;
  logic [1:0]    aborted_w;
  logic [1:0]    sel_w [2];
  logic [CW-1:0] iter_w [2];
  assign busy_w     = {bus2.busy, bus0.busy};
  assign done_w     = {bus2.done, bus0.done};
  assign ld_in_w    = {bus2.ld_in, bus0.ld_in};
  assign ld_acc_w   = {bus2.ld_acc, bus0.ld_acc};
  assign ld_term_w  = {bus2.ld_term, bus0.ld_term};
  assign clr_term_w = {bus2.clr_term, bus0.clr_term};
  assign ld_res_w   = {bus2.ld_res, bus0.ld_res};
  assign clr_all_w  = {bus2.clr_all, bus0.clr_all};
  assign sel_w[0]   = bus0.sel;
  assign sel_w[1]   = bus2.sel;
  assign iter_w[0]  = bus0.iter;
  assign iter_w[1]  = bus2.iter;
`ifdef ABORT_EN
  assign aborted_w  = {bus2.aborted, bus0.aborted};
`else
  assign aborted_w  = 2'b00;
`endif

  // Model: mode, cycle offset within a run, latched count, iter shown outside the loop.
  int m_mode [2], m_k [2], m_n [2], m_hold [2];
  bit m_done [2], m_ab [2];
  int n_chk = 0, n_pass = 0, cyc = 0;
  int c_acc [2], c_term [2], c_res [2], c_busy [2], c_sel1 [2], t_init [2], t_done [2];
  logic [1:0] prev_done = 2'b00;

  function automatic int lat(input int u);
    return (u == 0) ? 0 : 2;
  endfunction

  // Run layout: INIT, then N blocks of {CALC1, L x WAIT, CALC2}, then final CALC1, FIN.
  task automatic phase_of(input int u, output int p, output int it);
    int per, j;
    per = 2 + lat(u);
    p = PIdle;
    it = m_hold[u];
    if (m_mode[u] == MRun) begin
      if (m_k[u] == 0) begin
        p = PInit;
      end else begin
        j = m_k[u] - 1;
        if (j < m_n[u] * per) begin
          it = j / per;
          if (j % per == 0)            p = PTerm;
          else if (j % per <= lat(u))  p = PWait;
          else                         p = PCalc2;
        end else begin
          it = m_n[u];
          p = (j == m_n[u] * per) ? PFinal : PFin;
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    int p, it, e_sel;
    bit rs;
    @(negedge clk);
    rs = reset;
    for (int u = 0; u < 2; u++) begin
      phase_of(u, p, it);
      case (p)
        PTerm, PWait: e_sel = 1;
        PCalc2:       e_sel = 2;
        PFin:         e_sel = 3;
        default:      e_sel = 0;
      endcase
      check($sformatf("u%0d.busy", u), int'(busy_w[u]), int'(m_mode[u] == MRun));
      check($sformatf("u%0d.ld_in", u), int'(ld_in_w[u]), int'(!rs && p == PInit));
      check($sformatf("u%0d.clr_term", u), int'(clr_term_w[u]), int'(!rs && p == PInit));
      check($sformatf("u%0d.ld_acc", u), int'(ld_acc_w[u]),
            int'(!rs && (p == PInit || p == PCalc2)));
      check($sformatf("u%0d.ld_term", u), int'(ld_term_w[u]), int'(!rs && p == PTerm));
      check($sformatf("u%0d.ld_res", u), int'(ld_res_w[u]),
            int'(!rs && p == PFin && !(AbortEn && abort)));
      check($sformatf("u%0d.clr_all", u), int'(clr_all_w[u]), int'(rs));
      check($sformatf("u%0d.sel", u), int'(sel_w[u]), e_sel);
      check($sformatf("u%0d.iter", u), int'(iter_w[u]), it);
      check($sformatf("u%0d.done", u), int'(done_w[u]), int'(m_done[u]));
      if (AbortEn) check($sformatf("u%0d.aborted", u), int'(aborted_w[u]), int'(m_ab[u]));
      c_acc[u]  += int'(ld_acc_w[u]);
      c_term[u] += int'(ld_term_w[u]);
      c_res[u]  += int'(ld_res_w[u]);
      c_busy[u] += int'(busy_w[u]);
      c_sel1[u] += int'(sel_w[u] == 2'b01);
      if (ld_in_w[u]) t_init[u] = cyc;
      if (done_w[u] && !prev_done[u]) t_done[u] = cyc;
    end
    prev_done = done_w;
    cyc++;
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      if (reset) begin
        m_mode[u] = MIdle; m_k[u] = 0; m_n[u] = 0; m_hold[u] = 0; m_done[u] = 0; m_ab[u] = 0;
      end else begin
        m_ab[u] = 0;
        case (m_mode[u])
          MIdle: if (start) m_mode[u] = MArm;
          MArm:  if (!start) begin m_mode[u] = MRun; m_k[u] = 0; end
          default: begin
            phase_of(u, p, it);
            if (AbortEn && abort) begin
              m_mode[u] = MIdle;
              m_ab[u] = 1;
              if (p != PInit) m_hold[u] = it;
            end else begin
              if (p == PInit) begin m_n[u] = int'(n_iter); m_done[u] = 0; m_hold[u] = 0; end
              if (p == PFin) begin m_done[u] = 1; m_mode[u] = MIdle; m_hold[u] = m_n[u]; end
              m_k[u]++;
            end
          end
        endcase
      end
    end
    #1;
  endtask

  task automatic press(input int n);
    n_iter = CW'(n);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    repeat (2) tick();
  endtask

  task automatic wait_quiet();
    int c = 0;
    while (busy_w != 2'b00 && c < 200) begin tick(); c++; end
    check("run_timeout", int'(busy_w), 0);
    tick();
  endtask

  int a0, t0, r0, b0, a2, t2, b2, s2;
  task automatic snap();
    a0 = c_acc[0]; t0 = c_term[0]; r0 = c_res[0]; b0 = c_busy[0];
    a2 = c_acc[1]; t2 = c_term[1]; b2 = c_busy[1]; s2 = c_sel1[1];
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_mode[u] = MIdle; m_k[u] = 0; m_n[u] = 0; m_hold[u] = 0; m_done[u] = 0; m_ab[u] = 0;
      c_acc[u] = 0; c_term[u] = 0; c_res[u] = 0; c_busy[u] = 0; c_sel1[u] = 0;
      t_init[u] = 0; t_done[u] = 0;
    end
    reset = 1'b1; start = 1'b0; abort = 1'b0; n_iter = '0;
    #1;
    repeat (2) tick();
    reset = 1'b0;
    check("reset_busy", int'(busy_w), 0);
    check("reset_done", int'(done_w), 0);
    check("reset_iter", int'(iter_w[0]), 0);
    repeat (2) tick();

    // 1: N=9, no wait states on dut0
    snap(); press(9); wait_quiet();
    check("t1_acc", c_acc[0] - a0, 10);
    check("t1_term", c_term[0] - t0, 9);
    check("t1_res", c_res[0] - r0, 1);
    check("t1_busy", c_busy[0] - b0, 21);
    check("t1_latency", t_done[0] - t_init[0], 21);
    check("t1_busy_lat2", c_busy[1] - b2, 39);
    check("t1_done", int'(done_w), 3);

    // 2: N=3, dut2 holds sel=01 for 3 cycles per iteration
    snap(); press(3); wait_quiet();
    check("t2_busy_lat2", c_busy[1] - b2, 15);
    check("t2_sel01_lat2", c_sel1[1] - s2, 9);
    check("t2_acc_lat2", c_acc[1] - a2, 4);
    check("t2_iter_end", int'(iter_w[1]), 3);
    check("t2_busy", c_busy[0] - b0, 9);

    // 3: N=0, INIT/CALC1/FIN only
    snap(); press(0); wait_quiet();
    check("t3_busy", c_busy[0] - b0, 3);
    check("t3_busy_lat2", c_busy[1] - b2, 3);
    check("t3_term", c_term[0] - t0 + c_term[1] - t2, 0);
    check("t3_res", c_res[0] - r0, 1);
    check("t3_done_at", t_done[0] - t_init[0], 3);

    // 5: held start never launches; n_iter changed mid-run is ignored
    snap(); n_iter = 4'd9; start = 1'b1;
    repeat (50) tick();
    check("t5_held_busy", c_busy[0] - b0 + c_busy[1] - b2, 0);
    start = 1'b0;
    repeat (4) tick();
    n_iter = 4'd2;
    wait_quiet();
    check("t5_busy", c_busy[0] - b0, 21);
    check("t5_acc", c_acc[0] - a0, 10);

    // 4: reset during CALC2 at iter=5
    press(9);
    begin
      int c = 0;
      while (!(sel_w[0] == 2'b10 && iter_w[0] == 4'd5) && c < 100) begin tick(); c++; end
      check("t4_reach_calc2", int'(sel_w[0] == 2'b10 && iter_w[0] == 4'd5), 1);
    end
    reset = 1'b1;
    #1;
    check("t4_clr_all", int'(bus0.clr_all), 1);
    check("t4_ld_acc", int'(bus0.ld_acc), 0);
    tick();
    reset = 1'b0;
    check("t4_busy", int'(busy_w), 0);
    check("t4_iter", int'(iter_w[0]), 0);
    check("t4_done", int'(done_w), 0);
    repeat (3) tick();

`ifdef ABORT_EN
    // 6: abort at iter=4
    snap(); press(9);
    begin
      int c = 0;
      while (iter_w[0] != 4'd4 && c < 100) begin tick(); c++; end
      check("t6_reach_iter4", int'(iter_w[0]), 4);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_busy", int'(bus0.busy), 0);
    check("t6_aborted", int'(bus0.aborted), 1);
    check("t6_done", int'(bus0.done), 0);
    tick();
    check("t6_aborted_pulse", int'(bus0.aborted), 0);
    check("t6_res", c_res[0] - r0, 0);
    wait_quiet();
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
